// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment scan driver.
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g lit, shown for non-BCD codes
//   SEG_GLYPHS : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   ANODE_OFF  : all anodes disabled (active-low)
//   anode_sel(): one-hot-low anode pattern for a digit index
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Entry order in the concatenation is 9 down to 0.
    localparam logic [9:0][6:0] SEG_GLYPHS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   i_code : 4-bit digit code
//   o_seg  : {g,f,e,d,c,b,a}, active-low; codes 10-15 decode to a dash
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_code < 4'd10) begin
            o_seg = SEG_GLYPHS[i_code];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a 4-digit common-anode display.
// A loaded value is held in a pending register and only copied into the
// displayed value when the scan wraps from digit 3 to digit 0, so a single
// refresh never mixes old and new digits.
// Ports:
//   clk            : system clock, rising edge
//   reset          : synchronous, active-high
//   bcd_in         : {d3,d2,d1,d0}, d0 rightmost
//   load           : one-cycle strobe capturing bcd_in
//   blank_lz       : 1 = blank leading zeros in d3..d1
//   dp_en          : per-digit decimal point enable, 1 = lit
//   an             : anode enables, active-low
//   seg            : {g,f,e,d,c,b,a}, active-low
//   dp             : decimal point, active-low
//   update_pending : a captured value is waiting for the frame boundary
//   frame_done     : one-cycle pulse when the scan wraps to digit 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        update_pending,
    output logic        frame_done
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_disp;
    logic [15:0]      r_pend;
    logic             r_pending;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_wrap;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      w_disp_nxt;
    logic [3:0]       w_nibble;
    logic [6:0]       w_dec_seg;
    logic             w_lz3;
    logic             w_lz2;
    logic             w_lz1;
    logic             w_blank;
    logic [6:0]       w_seg_nxt;

    always_comb begin
        w_tick    = (r_cnt == CNT_LAST);
        w_wrap    = w_tick && (r_idx == 2'd3);
        w_idx_nxt = w_tick ? (r_idx + 2'd1) : r_idx;

        // A load landing on the wrap edge bypasses pend and supersedes it.
        w_disp_nxt = r_disp;
        if (w_wrap) begin
            if (load) begin
                w_disp_nxt = bcd_in;
            end else if (r_pending) begin
                w_disp_nxt = r_pend;
            end
        end
    end

    // Outputs are computed from the post-edge index and value so that a
    // frame-boundary update is visible on the very edge it is taken.
    always_comb begin
        case (w_idx_nxt)
            2'd0:    w_nibble = w_disp_nxt[3:0];
            2'd1:    w_nibble = w_disp_nxt[7:4];
            2'd2:    w_nibble = w_disp_nxt[11:8];
            default: w_nibble = w_disp_nxt[15:12];
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_code (w_nibble),
        .o_seg  (w_dec_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    // Invalid codes are non-zero, so they are never blanked.
    always_comb begin
        w_lz3 = (w_disp_nxt[15:12] == 4'd0);
        w_lz2 = w_lz3 && (w_disp_nxt[11:8] == 4'd0);
        w_lz1 = w_lz2 && (w_disp_nxt[7:4] == 4'd0);
        case (w_idx_nxt)
            2'd1:    w_blank = blank_lz && w_lz1;
            2'd2:    w_blank = blank_lz && w_lz2;
            2'd3:    w_blank = blank_lz && w_lz3;
            default: w_blank = 1'b0;
        endcase
        w_seg_nxt = w_blank ? SEG_BLANK : w_dec_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_disp       <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pending    <= 1'b0;
            r_an         <= ANODE_OFF;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : (r_cnt + CNT_W'(1));
            r_idx        <= w_idx_nxt;
            r_disp       <= w_disp_nxt;
            r_frame_done <= w_wrap;

            if (load) begin
                r_pend <= bcd_in;
            end

            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            // Display outputs only move on slot boundaries; they hold between.
            if (w_tick) begin
                r_an  <= anode_sel(w_idx_nxt);
                r_seg <= w_seg_nxt;
                r_dp  <= ~dp_en[w_idx_nxt];
            end
        end
    end

    assign an             = r_an;
    assign seg            = r_seg;
    assign dp             = r_dp;
    assign update_pending = r_pending;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Table-driven bench for seg7_scan_driver with TICK_DIV=4. Each table row
// applies its inputs for one clock (load lasts only that clock), holds the
// remaining inputs for cyc-1 further clocks, then compares all outputs.
module tb_seg7_scan_driver;

    localparam int TD = 4;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        update_pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.TICK_DIV(TD)) dut (
        .clk            (clk),
        .reset          (reset),
        .bcd_in         (bcd_in),
        .load           (load),
        .blank_lz       (blank_lz),
        .dp_en          (dp_en),
        .an             (an),
        .seg            (seg),
        .dp             (dp),
        .update_pending (update_pending),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic        rst;
        logic        ld;
        logic [15:0] bcd;
        logic        blz;
        logic [3:0]  dpen;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_up;
        logic        e_fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, int cyc, logic rst, logic ld,
                                logic [15:0] bcd, logic blz, logic [3:0] dpen,
                                logic [3:0] e_an, logic [6:0] e_seg,
                                logic e_dp, logic e_up, logic e_fd);
        vec_t v;
        v.name = name; v.cyc = cyc; v.rst = rst; v.ld = ld; v.bcd = bcd;
        v.blz = blz; v.dpen = dpen; v.e_an = e_an; v.e_seg = e_seg;
        v.e_dp = e_dp; v.e_up = e_up; v.e_fd = e_fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fd_cnt;
        int an_chg;
        int onehot_bad;
        logic [3:0] prev_an;

        reset = 1'b1; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0; dp_en = 4'h0;

        //            name         cyc rst ld  bcd      blz dpen   an       seg dp up fd
        vecs.push_back(mk("reset",     2, 1, 0, 16'h0000, 0, 4'h0, 4'b1111, BL, 1, 0, 0));
        vecs.push_back(mk("dark_t1",   1, 0, 0, 16'h0000, 0, 4'h0, 4'b1111, BL, 1, 0, 0));
        vecs.push_back(mk("dark_t3",   2, 0, 0, 16'h0000, 0, 4'h0, 4'b1111, BL, 1, 0, 0));
        vecs.push_back(mk("first_d1",  1, 0, 0, 16'h0000, 0, 4'h0, 4'b1101, G0, 1, 0, 0));
        vecs.push_back(mk("hold_d1",   3, 0, 0, 16'h0000, 0, 4'h0, 4'b1101, G0, 1, 0, 0));
        vecs.push_back(mk("d2",        1, 0, 0, 16'h0000, 0, 4'h0, 4'b1011, G0, 1, 0, 0));
        vecs.push_back(mk("d3",        4, 0, 0, 16'h0000, 0, 4'h0, 4'b0111, G0, 1, 0, 0));
        vecs.push_back(mk("wrap1",     4, 0, 0, 16'h0000, 0, 4'h0, 4'b1110, G0, 1, 0, 1));
        vecs.push_back(mk("fd_drop",   1, 0, 0, 16'h0000, 0, 4'h0, 4'b1110, G0, 1, 0, 0));
        vecs.push_back(mk("ld1234",    1, 0, 1, 16'h1234, 0, 4'h0, 4'b1110, G0, 1, 1, 0));
        vecs.push_back(mk("old_glyph", 2, 0, 0, 16'h0000, 0, 4'h0, 4'b1101, G0, 1, 1, 0));
        vecs.push_back(mk("wrap_1234", 12, 0, 0, 16'h0000, 0, 4'h0, 4'b1110, G4, 1, 0, 1));
        vecs.push_back(mk("d3_is_1",   12, 0, 0, 16'h0000, 0, 4'h0, 4'b0111, G1, 1, 0, 0));
        vecs.push_back(mk("ld1111",    1, 0, 1, 16'h1111, 0, 4'h0, 4'b0111, G1, 1, 1, 0));
        vecs.push_back(mk("ld2222",    1, 0, 1, 16'h2222, 0, 4'h0, 4'b0111, G1, 1, 1, 0));
        vecs.push_back(mk("wrap_2222", 2, 0, 0, 16'h0000, 0, 4'h0, 4'b1110, G2, 1, 0, 1));
        vecs.push_back(mk("pre_wrap",  15, 0, 0, 16'h0000, 0, 4'h0, 4'b0111, G2, 1, 0, 0));
        vecs.push_back(mk("ld_on_wrap", 1, 0, 1, 16'h0567, 0, 4'h0, 4'b1110, G7, 1, 0, 1));
        vecs.push_back(mk("d1_is_6",   4, 0, 0, 16'h0000, 0, 4'h0, 4'b1101, G6, 1, 0, 0));
        vecs.push_back(mk("ld0005",    1, 0, 1, 16'h0005, 1, 4'h0, 4'b1101, G6, 1, 1, 0));
        vecs.push_back(mk("blz_d2_5",  3, 0, 0, 16'h0000, 1, 4'h0, 4'b1011, G5, 1, 1, 0));
        vecs.push_back(mk("blz_d3_0",  4, 0, 0, 16'h0000, 1, 4'h0, 4'b0111, BL, 1, 1, 0));
        vecs.push_back(mk("wrap_0005", 4, 0, 0, 16'h0000, 1, 4'h2, 4'b1110, G5, 1, 0, 1));
        vecs.push_back(mk("blz_d1_dp", 4, 0, 0, 16'h0000, 1, 4'h2, 4'b1101, BL, 0, 0, 0));
        vecs.push_back(mk("blz_d2",    4, 0, 0, 16'h0000, 1, 4'h2, 4'b1011, BL, 1, 0, 0));
        vecs.push_back(mk("ld00A0",    1, 0, 1, 16'h00A0, 1, 4'h2, 4'b1011, BL, 1, 1, 0));
        vecs.push_back(mk("blz_d3",    3, 0, 0, 16'h0000, 1, 4'h2, 4'b0111, BL, 1, 1, 0));
        vecs.push_back(mk("wrap_00A0", 4, 0, 0, 16'h0000, 1, 4'h2, 4'b1110, G0, 1, 0, 1));
        vecs.push_back(mk("dash_d1",   4, 0, 0, 16'h0000, 1, 4'h2, 4'b1101, DA, 0, 0, 0));
        vecs.push_back(mk("blank_d2",  4, 0, 0, 16'h0000, 1, 4'h2, 4'b1011, BL, 1, 0, 0));
        vecs.push_back(mk("blank_d3",  4, 0, 0, 16'h0000, 1, 4'h2, 4'b0111, BL, 1, 0, 0));
        vecs.push_back(mk("ld9999",    1, 0, 1, 16'h9999, 0, 4'h0, 4'b0111, BL, 1, 1, 0));
        vecs.push_back(mk("rst_mid",   1, 1, 0, 16'h0000, 0, 4'h0, 4'b1111, BL, 1, 0, 0));
        vecs.push_back(mk("restart",   4, 0, 0, 16'h0000, 0, 4'h0, 4'b1101, G0, 1, 0, 0));
        vecs.push_back(mk("restart_wr", 12, 0, 0, 16'h0000, 0, 4'h0, 4'b1110, G0, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            load     = vecs[i].ld;
            bcd_in   = vecs[i].bcd;
            blank_lz = vecs[i].blz;
            dp_en    = vecs[i].dpen;
            tick1();
            load = 1'b0;
            for (int c = 1; c < vecs[i].cyc; c++) tick1();
            chk({vecs[i].name, ".an"},  {12'h0, an},             {12'h0, vecs[i].e_an});
            chk({vecs[i].name, ".seg"}, {9'h0, seg},             {9'h0, vecs[i].e_seg});
            chk({vecs[i].name, ".dp"},  {15'h0, dp},             {15'h0, vecs[i].e_dp});
            chk({vecs[i].name, ".up"},  {15'h0, update_pending}, {15'h0, vecs[i].e_up});
            chk({vecs[i].name, ".fd"},  {15'h0, frame_done},     {15'h0, vecs[i].e_fd});
        end

        // Free-running scan over four frames: one frame_done per 16 cycles,
        // an changes once per digit slot and is always one-hot-low.
        fd_cnt = 0; an_chg = 0; onehot_bad = 0;
        prev_an = an;
        for (int c = 0; c < 16 * TD; c++) begin
            tick1();
            if (frame_done) fd_cnt++;
            if (an !== prev_an) an_chg++;
            if (!(an == 4'b1110 || an == 4'b1101 || an == 4'b1011 || an == 4'b0111))
                onehot_bad++;
            prev_an = an;
        end
        chk("scan.frame_done_count", 16'(fd_cnt), 16'd4);
        chk("scan.an_changes", 16'(an_chg), 16'd16);
        chk("scan.an_onehot_bad", 16'(onehot_bad), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Consumer end of the BCD digit path.
- Takes four packed BCD digits and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Drives active-low anodes, segments and decimal point.
- New digit values are taken by a load strobe and applied only at a frame boundary, so a refresh never shows a mix of old and new digits.

## Interface
Parameters:
- TICK_DIV, default 100_000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); benches use 4; legal range ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- bcd_in  input  16  digits {d3,d2,d1,d0}, 4 bits each, d0 rightmost.
- load  input  1  one-cycle strobe; captures bcd_in.
- blank_lz  input  1  1 = blank leading zeros in d3..d1.
- dp_en  input  4  per-digit decimal point enable, 1 = lit.
- an  output  4  anode enables, active-low, one-hot-low when scanning.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- update_pending  output  1  captured value waiting for the frame boundary.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
Registers:
- tick counter (0..TICK_DIV-1)
- 2-bit digit index
- 16-bit display value (disp)
- 16-bit pending value (pend)
- pending flag

Tick:
- tick = (counter == TICK_DIV-1); counter then returns to 0.
- On tick, index advances 0→1→2→3→0.

Load:
- load captures bcd_in into pend and sets update_pending.
- A second load while pending overwrites pend; last value wins.

Wrap tick (index==3):
- Index goes to 0; frame_done pulses.
- If pending: disp←pend, pending cleared.
- If load coincides with the wrap tick: bcd_in goes straight into disp, pending cleared. Any older pend is discarded.

Decode, per active digit from the disp nibble:
- Codes 0–9 → standard glyphs: 0=1000000, 1=1111001, 8=0000000.
- Codes 10–15 → dash, seg=0111111.

Leading-zero blanking (blank_lz=1):
- Digit k (k=3..1) shows blank (seg=1111111) when its nibble and all nibbles above it are 0.
- d0 is never blanked.
- Blanking does not apply to invalid codes.
- dp follows dp_en[index] even on blanked digits.

Outputs:
- an = ~(1<<index).
- seg, dp, an are registered.
- They reflect the post-edge index and disp, including a disp update taken on the same edge.

## Timing
Reset values:
- counter=0, index=0, disp=0, pend=0, pending=0.
- an=1111, seg=1111111, dp=1, frame_done=0.
- Display stays dark until the first tick, TICK_DIV cycles after reset deasserts; that tick shows digit 1.

Latency and refresh:
- Each digit is held for exactly TICK_DIV cycles.
- Full frame = 4·TICK_DIV cycles.
- Load-to-visible latency: from 1 up to 4·TICK_DIV cycles, ending at the next wrap tick.
- update_pending rises the cycle after load and falls on the wrap edge.

Reset mid-operation:
- All state returns to reset values on the next edge.
- A pending value is lost.

Input sampling:
- blank_lz and dp_en are sampled every cycle.
- Changes are visible at the next register update (each tick edge); between ticks outputs hold.

## Structure
- seg7_pkg holds:
  - segment constants SEG_BLANK=1111111 and SEG_DASH=0111111
  - the glyph table for 0–9
  - the ANODE_OFF constant
- Sub-module bcd_to_seg7 is combinational: 4-bit code in, 7-bit active-low segments out, dash for codes 10–15.
- It is instantiated once on the selected nibble; blanking muxes after it.

## Test plan
All scenarios use TICK_DIV=4.
- Reset release, no load → an=1111 for 4 cycles, then an cycles 1101,1011,0111,1110 every 4 cycles; seg=1000000 on each digit; frame_done pulses once per 16 cycles.
- load with bcd_in=16'h1234 mid-frame → update_pending=1, digits keep old glyphs until the wrap; then d0 shows 4 (1111001 for d3=1 later in the frame); pending clears on the wrap edge.
- Two loads (16'h1111 then 16'h2222) before the wrap → only 2222 ever displayed.
- load 16'h0567 coinciding with the wrap tick → d0 immediately shows 7 on that edge, update_pending stays 0.
- blank_lz=1 with 16'h0005 → d3..d1 seg=1111111, d0 shows 5; with 16'h00A0 → d3,d2 blank, d1 dash (0111111), d0 shows 0.
- reset asserted with a pending load → next cycle an=1111, update_pending=0; after restart, digits show 0.
